// File: rtl/rf_write_scheduler.sv
// rf_write_scheduler
//   Shares the single register-file write port between the pipeline
//   write-back stage (WB) and the multi-cycle load/multiply unit (MCU).
//   It also keeps a busy scoreboard of registers with outstanding MCU writes
//   and flags read/write hazards to the issue stage.
//
// Ports:
//   clk, rst                    clock (rising edge), async active-low reset
//   wb_en/wb_dest/wb_data       WB write request; wb_ready = accepted this cycle
//   mcu_valid/mcu_dest/mcu_data MCU write request; mcu_ready = accepted this cycle
//   alloc_en/alloc_dest         issue stage dispatches a multi-cycle op to alloc_dest
//   chk_src1/chk_src2/chk_dest  registers of the instruction being issued
//   hazard                      combinational: one of the chk registers is busy
//   rf_we/rf_dest/rf_data       registered register-file write port (1-cycle latency)
//   busy_cnt                    registered number of busy scoreboard entries
//
// Optional feature (macro RF_STARVE_GUARD_EN):
//   After STARVE_LIMIT consecutive MCU wait cycles, WB is stalled for one
//   cycle and the MCU is granted. Without the macro WB has strict priority.
module rf_write_scheduler #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 16
`ifdef RF_STARVE_GUARD_EN
    ,
    parameter int unsigned STARVE_LIMIT = 4
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wb_en,
    input  logic [3:0]        wb_dest,
    input  logic [DATA_W-1:0] wb_data,
    output logic              wb_ready,
    input  logic              mcu_valid,
    input  logic [3:0]        mcu_dest,
    input  logic [DATA_W-1:0] mcu_data,
    output logic              mcu_ready,
    input  logic              alloc_en,
    input  logic [3:0]        alloc_dest,
    input  logic [3:0]        chk_src1,
    input  logic [3:0]        chk_src2,
    input  logic [3:0]        chk_dest,
    output logic              hazard,
    output logic              rf_we,
    output logic [3:0]        rf_dest,
    output logic [DATA_W-1:0] rf_data,
    output logic [4:0]        busy_cnt
);

    localparam int unsigned CNT_W = 5;

    logic              guard_c;
    logic              grant_wb;
    logic              grant_mcu;
    logic [NREG-1:0]   busy_q;
    logic [NREG-1:0]   set_mask;
    logic [NREG-1:0]   clr_mask;
    logic [NREG-1:0]   busy_nxt;
    logic [CNT_W-1:0]  cnt_nxt;

`ifdef RF_STARVE_GUARD_EN
    logic [2:0] starve_q;

    // Guard fires while the MCU is still waiting and has hit the limit.
    assign guard_c = mcu_valid && (starve_q == 3'(STARVE_LIMIT));

    // Consecutive MCU wait cycles; cleared on grant or when MCU goes idle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q <= 3'd0;
        end else if (grant_mcu || !mcu_valid) begin
            starve_q <= 3'd0;
        end else if (!mcu_ready) begin
            starve_q <= starve_q + 3'd1;
        end
    end
`else
    assign guard_c = 1'b0;
`endif

    // Arbitration: WB first unless the starve guard stalls it.
    always_comb begin
        wb_ready  = !guard_c;
        mcu_ready = guard_c || !wb_en;
        grant_wb  = wb_en && wb_ready;
        grant_mcu = mcu_valid && mcu_ready && !grant_wb;
    end

    // Next scoreboard: clear on MCU grant, then set on alloc so set wins.
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (alloc_en) begin
            set_mask[alloc_dest] = 1'b1;
        end
        if (grant_mcu) begin
            clr_mask[mcu_dest] = 1'b1;
        end
        busy_nxt = (busy_q & ~clr_mask) | set_mask;
        // Population count is bounded by NREG, so it can never wrap.
        cnt_nxt = '0;
        for (int unsigned i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + CNT_W'(busy_nxt[i]);
        end
    end

    assign hazard = busy_q[chk_src1] | busy_q[chk_src2] | busy_q[chk_dest];

    // Scoreboard and busy count registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy_q   <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Registered write port; dest/data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_we   <= 1'b0;
            rf_dest <= '0;
            rf_data <= '0;
        end else begin
            rf_we <= grant_wb || grant_mcu;
            if (grant_wb) begin
                rf_dest <= wb_dest;
                rf_data <= wb_data;
            end else if (grant_mcu) begin
                rf_dest <= mcu_dest;
                rf_data <= mcu_data;
            end
        end
    end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Self-checking bench for rf_write_scheduler: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a
// behavioural model of the arbitration and scoreboard rules.
module tb_rf_write_scheduler;

    localparam int unsigned DATA_W = 32;
    localparam int          LIMIT  = 4;
`ifdef RF_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              wb_en;
    logic [3:0]        wb_dest;
    logic [DATA_W-1:0] wb_data;
    logic              wb_ready;
    logic              mcu_valid;
    logic [3:0]        mcu_dest;
    logic [DATA_W-1:0] mcu_data;
    logic              mcu_ready;
    logic              alloc_en;
    logic [3:0]        alloc_dest;
    logic [3:0]        chk_src1;
    logic [3:0]        chk_src2;
    logic [3:0]        chk_dest;
    logic              hazard;
    logic              rf_we;
    logic [3:0]        rf_dest;
    logic [DATA_W-1:0] rf_data;
    logic [4:0]        busy_cnt;

    always #5 clk = ~clk;

    rf_write_scheduler #(.DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst),
        .wb_en(wb_en), .wb_dest(wb_dest), .wb_data(wb_data), .wb_ready(wb_ready),
        .mcu_valid(mcu_valid), .mcu_dest(mcu_dest), .mcu_data(mcu_data),
        .mcu_ready(mcu_ready),
        .alloc_en(alloc_en), .alloc_dest(alloc_dest),
        .chk_src1(chk_src1), .chk_src2(chk_src2), .chk_dest(chk_dest),
        .hazard(hazard),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data), .busy_cnt(busy_cnt)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    bit          m_busy[16];
    int          m_cnt;
    bit          m_we;
    logic [3:0]  m_dest;
    logic [31:0] m_data;
    int          m_starve;
    bit          m_waiting;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_busy[i] = 1'b0;
        m_cnt     = 0;
        m_we      = 1'b0;
        m_dest    = 4'd0;
        m_data    = 32'd0;
        m_starve  = 0;
        m_waiting = 1'b0;
    endtask

    function automatic bit m_guard();
        return GUARD && mcu_valid && (m_starve == LIMIT);
    endfunction

    function automatic bit m_wb_ready();
        return !m_guard();
    endfunction

    function automatic bit m_mcu_ready();
        return m_guard() || !wb_en;
    endfunction

    // Apply one clock edge to the model using the inputs currently driven.
    task automatic model_edge();
        bit mr      = m_mcu_ready();
        bit gw      = wb_en && m_wb_ready();
        bit gm      = mcu_valid && mr && !gw;
        bit newly   = alloc_en && !m_busy[alloc_dest];
        bit cleared = gm && m_busy[mcu_dest] && !(alloc_en && alloc_dest == mcu_dest);
        m_we = gw || gm;
        if (gw) begin
            m_dest = wb_dest;
            m_data = wb_data;
        end else if (gm) begin
            m_dest = mcu_dest;
            m_data = mcu_data;
        end
        if (gm) m_busy[mcu_dest] = 1'b0;
        if (alloc_en) m_busy[alloc_dest] = 1'b1;
        if (newly && !cleared) m_cnt = m_cnt + 1;
        else if (cleared && !newly) m_cnt = m_cnt - 1;
        if (m_cnt > 16) m_cnt = 16;
        if (m_cnt < 0) m_cnt = 0;
        if (gm || !mcu_valid) m_starve = 0;
        else if (!mr) m_starve = (m_starve + 1) % 8;
        m_waiting = mcu_valid && !mr;
    endtask

    // Compare every DUT output against the model for the current cycle.
    task automatic compare_all();
        #1;
        chk("wb_ready",  32'(wb_ready),  32'(m_wb_ready()));
        chk("mcu_ready", 32'(mcu_ready), 32'(m_mcu_ready()));
        chk("hazard",    32'(hazard),
            32'(m_busy[chk_src1] | m_busy[chk_src2] | m_busy[chk_dest]));
        chk("rf_we",     32'(rf_we),     32'(m_we));
        chk("rf_dest",   32'(rf_dest),   32'(m_dest));
        chk("rf_data",   rf_data,        m_data);
        chk("busy_cnt",  32'(busy_cnt),  32'(m_cnt));
    endtask

    task automatic step();
        compare_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        wb_en = 0; wb_dest = 0; wb_data = 0;
        mcu_valid = 0; mcu_dest = 0; mcu_data = 0;
        alloc_en = 0; alloc_dest = 0;
        chk_src1 = 0; chk_src2 = 0; chk_dest = 0;
    endtask

    int first_grant;

    initial begin
        rst = 1'b0;
        idle_inputs();
        model_reset();
        @(negedge clk);
        @(negedge clk);
        chk("reset_rf_we", 32'(rf_we), 32'd0);
        chk("reset_busy_cnt", 32'(busy_cnt), 32'd0);
        rst = 1'b1;

        // Single WB write and hold afterwards
        wb_en = 1; wb_dest = 4'd5; wb_data = 32'h1234;
        step();
        chk("wb_single_we", 32'(rf_we), 32'd1);
        chk("wb_single_dest", 32'(rf_dest), 32'd5);
        chk("wb_single_data", rf_data, 32'h1234);
        wb_en = 0;
        step();
        chk("wb_single_we_off", 32'(rf_we), 32'd0);
        chk("wb_single_dest_hold", 32'(rf_dest), 32'd5);

        // Load state, then reset mid-operation with WB still requesting
        wb_en = 1; wb_dest = 4'd3; wb_data = 32'hAA;
        alloc_en = 1; alloc_dest = 4'd3;
        step();
        chk("pre_reset_cnt", 32'(busy_cnt), 32'd1);
        alloc_en = 0;
        rst = 1'b0;
        #1;
        chk("async_reset_we", 32'(rf_we), 32'd0);
        chk("async_reset_data", rf_data, 32'd0);
        chk("async_reset_cnt", 32'(busy_cnt), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        chk("in_reset_we", 32'(rf_we), 32'd0);
        rst = 1'b1;
        wb_en = 0;
        step();
        chk("post_reset_we", 32'(rf_we), 32'd0);
        chk("post_reset_data", rf_data, 32'd0);
        chk("post_reset_cnt", 32'(busy_cnt), 32'd0);

        // Collision: WB wins, MCU follows the next cycle
        wb_en = 1; wb_dest = 4'd2; wb_data = 32'h11;
        mcu_valid = 1; mcu_dest = 4'd7; mcu_data = 32'h22;
        #1;
        chk("collide_mcu_ready", 32'(mcu_ready), 32'd0);
        step();
        chk("collide_wb_dest", 32'(rf_dest), 32'd2);
        chk("collide_wb_data", rf_data, 32'h11);
        wb_en = 0;
        #1;
        chk("collide_mcu_ready2", 32'(mcu_ready), 32'd1);
        step();
        chk("collide_mcu_dest", 32'(rf_dest), 32'd7);
        chk("collide_mcu_data", rf_data, 32'h22);
        mcu_valid = 0;

        // Scoreboard set and clear of r9
        alloc_en = 1; alloc_dest = 4'd9;
        step();
        alloc_en = 0; chk_src2 = 4'd9;
        chk("sb_cnt_set", 32'(busy_cnt), 32'd1);
        #1;
        chk("sb_hazard_set", 32'(hazard), 32'd1);
        mcu_valid = 1; mcu_dest = 4'd9; mcu_data = 32'h99;
        step();
        mcu_valid = 0;
        #1;
        chk("sb_hazard_clr", 32'(hazard), 32'd0);
        chk("sb_cnt_clr", 32'(busy_cnt), 32'd0);
        chk_src2 = 0;

        // Simultaneous alloc/clear of r4, then alloc r1 while clearing r4
        alloc_en = 1; alloc_dest = 4'd4;
        step();
        mcu_valid = 1; mcu_dest = 4'd4; mcu_data = 32'h44;
        step();
        chk("same_reg_cnt", 32'(busy_cnt), 32'd1);
        alloc_en = 0; mcu_valid = 0; chk_dest = 4'd4;
        #1;
        chk("same_reg_busy", 32'(hazard), 32'd1);
        alloc_en = 1; alloc_dest = 4'd1;
        mcu_valid = 1; mcu_dest = 4'd4;
        step();
        chk("swap_cnt", 32'(busy_cnt), 32'd1);
        alloc_en = 0; mcu_valid = 0;
        #1;
        chk("swap_r4_free", 32'(hazard), 32'd0);
        chk_src1 = 4'd1;
        #1;
        chk("swap_r1_busy", 32'(hazard), 32'd1);
        chk_src1 = 0; chk_dest = 0;
        mcu_valid = 1; mcu_dest = 4'd1;
        step();
        mcu_valid = 0;

        // Register 15 scoreboarded like the rest
        alloc_en = 1; alloc_dest = 4'd15;
        step();
        alloc_en = 0; chk_src1 = 4'd15;
        chk("r15_cnt", 32'(busy_cnt), 32'd1);
        #1;
        chk("r15_hazard", 32'(hazard), 32'd1);
        mcu_valid = 1; mcu_dest = 4'd15; mcu_data = 32'hF0;
        step();
        mcu_valid = 0; chk_src1 = 0;

        // Starvation under back-to-back WB traffic
        first_grant = 0;
        wb_en = 1; wb_dest = 4'd6; wb_data = 32'h66;
        mcu_valid = 1; mcu_dest = 4'd10; mcu_data = 32'h55;
        for (int k = 1; k <= 10; k++) begin
            bit granted_now;
            #1;
            granted_now = mcu_valid && mcu_ready;
            if (granted_now && first_grant == 0) first_grant = k;
            wb_data = wb_data + 1;
            step();
            if (granted_now) mcu_valid = 0;
        end
        chk("starve_first_grant", 32'(first_grant), GUARD ? 32'(LIMIT + 1) : 32'd0);
        idle_inputs();
        step();

        // Randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int wb_pct = (c < 1500) ? 50 : 90;
            if (c == 2000) begin
                rst = 1'b0;
                #1;
                chk("rand_reset_cnt", 32'(busy_cnt), 32'd0);
                chk("rand_reset_we", 32'(rf_we), 32'd0);
                model_reset();
                @(posedge clk);
                @(negedge clk);
                rst = 1'b1;
                mcu_valid = 0;
            end
            wb_en   = ($urandom_range(0, 99) < wb_pct);
            wb_dest = 4'($urandom);
            wb_data = $urandom;
            if (!m_waiting) begin
                mcu_valid = ($urandom_range(0, 99) < 40);
                mcu_dest  = 4'($urandom);
                mcu_data  = $urandom;
            end
            alloc_en   = ($urandom_range(0, 3) == 0);
            alloc_dest = 4'($urandom);
            chk_src1   = 4'($urandom);
            chk_src2   = 4'($urandom);
            chk_dest   = 4'($urandom);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rf_write_scheduler.md
Name: rf_write_scheduler

Overview:
- Shares the single register-file write port between two requesters:
  - the pipeline write-back stage (WB, port A);
  - the multi-cycle load/multiply unit (MCU, port B).
- Keeps a 16-entry busy scoreboard of registers with outstanding MCU writes and flags read/write hazards to the issue stage.
- Sits between WB/MCU and the register file's write inputs (write_back_en, dest_wb, result_wb).

Parameters:
- DATA_W, 32, write data width.
- NREG, 16, number of architectural registers (index width 4).
- STARVE_LIMIT, 4, consecutive MCU wait cycles before the guard forces an MCU grant (used only with the optional feature).

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- wb_en  in  1  WB write request.
- wb_dest  in  4  WB destination register.
- wb_data  in  DATA_W  WB write data.
- wb_ready  out  1  WB request accepted this cycle.
- mcu_valid  in  1  MCU write request.
- mcu_dest  in  4  MCU destination register.
- mcu_data  in  DATA_W  MCU write data.
- mcu_ready  out  1  MCU request accepted this cycle.
- alloc_en  in  1  issue stage dispatches a multi-cycle op.
- alloc_dest  in  4  destination register of that op.
- chk_src1, chk_src2, chk_dest  in  4 each  registers of the instruction being issued.
- hazard  out  1  instruction must not issue.
- rf_we  out  1  register-file write enable.
- rf_dest  out  4  register-file write index.
- rf_data  out  DATA_W  register-file write data.
- busy_cnt  out  5  number of busy scoreboard entries.

Behaviour:
- Reset (rst=0, asynchronous):
  - rf_we=0, rf_dest=0, rf_data=0, busy_cnt=0.
  - All busy bits cleared; starve counter=0.
  - Any in-flight grant is discarded.
- Arbitration (combinational, same cycle):
  - Default priority is WB over MCU.
  - wb_ready=1.
  - mcu_ready = !wb_en.
  - A request is granted when valid && ready.
  - At most one grant per cycle.
- Write port (registered, latency 1 cycle):
  - On a grant, at the next rising edge: rf_we=1, rf_dest and rf_data take the granted requester's dest/data.
  - With no grant: rf_we=0; rf_dest and rf_data hold their previous values.
- MCU hold rule: MCU holds mcu_dest and mcu_data stable while mcu_valid=1 and mcu_ready=0.
- Scoreboard set: on alloc_en, busy[alloc_dest] is set at the clock edge.
- Scoreboard clear: busy[mcu_dest] is cleared at the edge of the MCU grant cycle.
- Same register allocated and cleared in the same cycle: set wins, entry stays busy.
- alloc_en on an already-busy register: entry stays busy, busy_cnt unchanged. The issue stage must not allocate while hazard=1.
- busy_cnt:
  - +1 per newly set entry, −1 per cleared entry.
  - Both events on different registers in one cycle leave it unchanged.
  - Saturates at 16; never wraps.
- hazard = busy[chk_src1] | busy[chk_src2] | busy[chk_dest].
  - Combinational, from current (pre-edge) scoreboard state.
  - A register cleared at this edge is not hazardous in the following cycle.
- WB requests never touch the scoreboard.
- Register 15 is scoreboarded like any other register.

Optional Feature:
- Macro: RF_STARVE_GUARD_EN.
- Without the macro:
  - strict WB priority; wb_ready is constant 1;
  - MCU may starve indefinitely under back-to-back WB traffic.
- With the macro, a 3-bit starve counter is added:
  - increments each cycle mcu_valid && !mcu_ready;
  - resets on an MCU grant or when mcu_valid=0.
- Guard action:
  - When the counter equals STARVE_LIMIT, the next cycle sets wb_ready=0 and mcu_ready=1.
  - The MCU is granted and the counter returns to 0.
  - WB holds its request (pipeline stall) and is granted the cycle after.
- Guard timing: worst-case MCU wait is STARVE_LIMIT+1 cycles.

Test Plan:
1. Reset mid-operation: wb_en=1, dest=3, data=0xAA; assert rst=0 before the edge -> rf_we=0, rf_data=0, busy_cnt=0 immediately and after release.
2. Single WB write: wb_en=1, dest=5, data=0x1234 -> next cycle rf_we=1, rf_dest=5, rf_data=0x1234; following cycle rf_we=0.
3. Collision: wb_en=1 (r2, 0x11) and mcu_valid=1 (r7, 0x22) in the same cycle -> mcu_ready=0, r2 written first; next cycle with wb_en=0 -> mcu_ready=1, r7=0x22 written.
4. Scoreboard set/clear:
   - alloc_en r9 -> busy_cnt=1; chk_src2=9 -> hazard=1.
   - MCU grant to r9 -> next cycle hazard=0, busy_cnt=0.
5. Simultaneous alloc and clear of r4 (r4 already busy) -> r4 stays busy, busy_cnt unchanged. Alloc r1 while clearing r4 -> busy_cnt unchanged.
6. Starvation guard (RF_STARVE_GUARD_EN, limit 4): wb_en held at 1, mcu_valid=1 -> the cycle after 4 MCU wait cycles wb_ready=0, MCU granted. Without the macro, MCU is never granted.
